// File: rtl/ste_peak_meter.sv
// Peak-hold level meter: windowed peak detection, scaling to a level code,
// then hold/linear-decay shaping with a registered level and update strobe.
module ste_peak_meter #(
  parameter int DATA_W     = 12,
  parameter int OUT_W      = 4,
  parameter int WIN_LEN    = 1024,
  parameter int HOLD_WIN   = 4,
  parameter int DECAY_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              clr_i,
  output logic [OUT_W-1:0]  level_o,
  output logic              level_update_o
);

  localparam int CNT_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int HOLD_W = (HOLD_WIN > 0) ? $clog2(HOLD_WIN + 1) : 1;

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WIN_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_WIN);
  localparam logic [OUT_W:0]    STEP      = (OUT_W + 1)'(DECAY_STEP);

  typedef enum logic {
    ST_HOLD  = 1'b0,
    ST_DECAY = 1'b1
  } state_t;

  logic [DATA_W-1:0] win_max_r;
  logic [CNT_W-1:0]  smp_cnt_r;
  logic [OUT_W-1:0]  disp_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  state_t            state_r;
  logic [OUT_W-1:0]  level_r;
  logic              update_r;

  logic              accept_s;
  logic              close_s;
  logic [DATA_W-1:0] peak_s;
  logic [OUT_W-1:0]  lvl_s;
  logic [OUT_W:0]    dec_s;
  logic [OUT_W-1:0]  floor_s;
  logic [OUT_W-1:0]  next_disp_s;
  logic [HOLD_W-1:0] next_hold_s;
  state_t            next_state_s;

  assign accept_s = sample_valid_i & ~clr_i;
  assign close_s  = accept_s & (smp_cnt_r == LAST_CNT);

  // Peak of the window including the current sample, and the hold/decay decision at close.
  always_comb begin
    peak_s       = (sample_i > win_max_r) ? sample_i : win_max_r;
    lvl_s        = peak_s[DATA_W-1 -: OUT_W];
    // Borrow out of the extra top bit means the decay went below zero.
    dec_s        = {1'b0, disp_r} - STEP;
    next_disp_s  = disp_r;
    next_hold_s  = hold_cnt_r;
    next_state_s = state_r;
    if (dec_s[OUT_W]) begin
      floor_s = '0;
    end else begin
      floor_s = dec_s[OUT_W-1:0];
    end
    if (lvl_s >= disp_r) begin
      next_disp_s  = lvl_s;
      next_hold_s  = HOLD_INIT;
      next_state_s = ST_HOLD;
    end else if ((state_r == ST_HOLD) && (hold_cnt_r != '0)) begin
      next_hold_s  = hold_cnt_r - HOLD_W'(1);
      next_state_s = ST_HOLD;
    end else begin
      next_state_s = ST_DECAY;
      next_disp_s  = (lvl_s > floor_s) ? lvl_s : floor_s;
    end
  end

  // Window accumulation, meter state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_max_r  <= '0;
      smp_cnt_r  <= '0;
      disp_r     <= '0;
      hold_cnt_r <= '0;
      state_r    <= ST_HOLD;
      level_r    <= '0;
      update_r   <= 1'b0;
    end else if (clr_i) begin
      win_max_r  <= '0;
      smp_cnt_r  <= '0;
      disp_r     <= '0;
      hold_cnt_r <= '0;
      state_r    <= ST_HOLD;
      level_r    <= '0;
      update_r   <= 1'b0;
    end else begin
      update_r <= 1'b0;
      if (close_s) begin
        win_max_r  <= '0;
        smp_cnt_r  <= '0;
        disp_r     <= next_disp_s;
        hold_cnt_r <= next_hold_s;
        state_r    <= next_state_s;
        level_r    <= next_disp_s;
        update_r   <= 1'b1;
      end else if (accept_s) begin
        win_max_r <= peak_s;
        smp_cnt_r <= smp_cnt_r + CNT_W'(1);
      end else begin
        win_max_r <= win_max_r;
        smp_cnt_r <= smp_cnt_r;
      end
    end
  end

  assign level_o        = level_r;
  assign level_update_o = update_r;

endmodule

// File: doc/ste_peak_meter.md
# ste_peak_meter

Peak-hold level meter that sits upstream of the multimeter LED bar driver and produces its level-data/update-strobe pair. It takes a stream of unsigned magnitude samples with a valid strobe, finds the peak over fixed windows of samples, and scales that peak to a small level code. It applies peak-hold and linear decay to the code and emits one registered level plus a one-cycle update strobe per window.

## Interface
- DATA_W, 12: input sample width (unsigned magnitude).
- OUT_W, 4: output level width; must satisfy 1 <= OUT_W <= DATA_W.
- WIN_LEN, 1024: samples per measurement window; must be >= 1.
- HOLD_WIN, 4: number of windows a new peak is held before decay starts; 0 means no hold.
- DECAY_STEP, 1: level LSBs removed per window while decaying; must be >= 1 and < 2^OUT_W.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_i  in  DATA_W  unsigned sample magnitude.
- sample_valid_i  in  1  sample_i is valid this cycle; any pattern is allowed, including back-to-back.
- clr_i  in  1  synchronous clear of the meter state.
- level_o  out  OUT_W  displayed level; held between updates.
- level_update_o  out  1  one-cycle pulse when level_o has been refreshed.

## Operation
- Registers:
  - win_max (DATA_W): running maximum of the current window.
  - smp_cnt ($clog2(WIN_LEN), minimum 1 bit): sample counter.
  - disp (OUT_W): displayed level.
  - hold_cnt ($clog2(HOLD_WIN+1), minimum 1 bit): hold counter.
  - state: HOLD or DECAY.
- Accepted sample (sample_valid_i=1 and clr_i=0):
  - If smp_cnt < WIN_LEN-1: win_max <= max(win_max, sample_i); smp_cnt++.
  - If smp_cnt == WIN_LEN-1, the window closes:
    - peak = max(win_max, sample_i), so the closing sample is included.
    - lvl = peak >> (DATA_W-OUT_W).
    - win_max <= 0; smp_cnt <= 0.
- Window close, disp/state update:
  - lvl >= disp: disp <= lvl; hold_cnt <= HOLD_WIN; state <= HOLD. An equal level also re-arms the hold.
  - lvl < disp, HOLD, hold_cnt > 0: hold_cnt--; disp unchanged. Once hold_cnt reaches 0 the state stays HOLD until the next close.
  - lvl < disp, HOLD, hold_cnt == 0: state <= DECAY, and the decay rule below applies in this same close.
  - lvl < disp, DECAY: disp <= max(lvl, sat0(disp - DECAY_STEP)), where sat0 floors at 0. Decay never undershoots the current window's level.
- Every window close sets level_o <= new disp and pulses level_update_o, even when the value is unchanged.
- clr_i=1: win_max, smp_cnt, disp, hold_cnt <= 0; state <= HOLD; level_o <= 0.
  - No level_update_o pulse is generated.
  - A sample presented in the same cycle is dropped.
  - clr_i has priority over window close.
- rst: every register and output is 0, state is HOLD; this holds immediately and asynchronously, including mid-window and mid-decay.
- Arithmetic:
  - Comparisons are unsigned.
  - Decay subtraction is done at OUT_W+1 bits and clamped at 0; there is no wrap-around.
  - smp_cnt wraps only through the window-close reset, never by overflow.

## Timing
- Throughput: one sample per cycle, with no backpressure and no ready signal.
- Latency: if the closing sample_valid_i is high in cycle k, then level_o shows the new value and level_update_o=1 in cycle k+1.
- level_update_o is high for exactly one cycle per window. Pulses are at least WIN_LEN cycles apart, or exactly 1 cycle apart when WIN_LEN=1 with back-to-back valids.
- level_o is stable at all other times and is directly connectable to the LED bar driver data/update inputs.
- Reset values: level_o=0, level_update_o=0.

## Test plan
Bench parameters: DATA_W=12, OUT_W=4, WIN_LEN=4, HOLD_WIN=2, DECAY_STEP=1 unless stated.
- Reset: assert rst asynchronously between edges, mid-window, and mid-decay -> level_o=0 and level_update_o=0 immediately. After release, the next full window starts counting from 0.
- Peak capture: valid samples 0x100, 0xF00, 0x200, 0x050 with gaps between them -> exactly one pulse, in the cycle after the 4th valid, with level_o=0xF.
- Hold then decay: after the peak-capture window, feed windows of all 0x000 -> successive level_o values 0xF, 0xF, 0xE, 0xD, ... 0x0, then 0x0 stays, with one pulse per window.
- Rise during decay: with disp=0xC in DECAY, feed a window peaking at 0xE80 -> level_o=0xE and state HOLD. The next two low windows still show 0xE.
- Decay floor: with DECAY_STEP=3, disp=0x5, hold expired, feed a window peaking at 0x450 -> level_o=0x4, not 0x2. Separately, disp=0x2 with a zero window -> level_o=0x0 (saturating, no wrap).
- Clear: two 0xFFF samples, then clr_i coincident with a third 0xFFF valid, then four 0x300 samples -> no pulse on the clear, and the first pulse afterwards shows level_o=0x3.
